jelly3_fifo_fwft: RTL and testbench

Parametrised single-clock first-word-fall-through FIFO with valid/ready stream ports, runtime almost-full/almost-empty thresholds, synchronous flush and an optional output register. Next generation of the jelly2 synchronous FIFO. Used as the general stream buffer between jelly3 pipeline stages and in front of DMA and bus bridges.

---
 rtl/jelly3_fifo_pkg.sv | 18 +
 rtl/jelly3_ram_simple_dualport.sv | 69 ++++++
 rtl/jelly3_fifo_fwft.sv | 205 ++++++++++++++++++++
 tb/tb_jelly3_fifo_fwft.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jelly3_fifo_pkg.sv
// jelly3_fifo_pkg
// Shared definitions for the jelly3 FIFO family.
//   RAM_TYPE_*  : accepted values of the RAM_TYPE storage-style parameter.
//   count_bits  : width of a fill counter for a given pointer width. Users derive
//                 their count type with
//                   typedef logic [count_bits(PTR_BITS)-1:0] count_t;
//                 so the counter can hold DEPTH itself and never overflows.

package jelly3_fifo_pkg;

  localparam string RAM_TYPE_DISTRIBUTED = "distributed";
  localparam string RAM_TYPE_BLOCK       = "block";

  function automatic int unsigned count_bits(input int unsigned ptr_bits);
    return ptr_bits + 1;
  endfunction

endpackage

// File: rtl/jelly3_ram_simple_dualport.sv
// jelly3_ram_simple_dualport
// Simple dual-port RAM: one write port, one read port with a registered output,
// single clock. RAM_TYPE selects the storage style ("distributed" or "block").
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_din   write data
//   rd_rst   synchronous reset of the read register (clears rd_dout)
//   rd_en    read strobe; rd_dout holds its value while low
//   rd_addr  read address
//   rd_dout  registered read data, valid one cycle after rd_en

module jelly3_ram_simple_dualport
  import jelly3_fifo_pkg::*;
#(
  parameter int    ADDR_BITS = 5,
  parameter int    DATA_BITS = 8,
  parameter string RAM_TYPE  = "distributed"
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_din,
  input  logic                 rd_rst,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_dout
);

  localparam int Depth = 2 ** ADDR_BITS;

  if (RAM_TYPE == RAM_TYPE_BLOCK) begin : g_block
    (* ram_style = "block" *)
    logic [DATA_BITS-1:0] mem [Depth];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_din;
      end
    end

    always_ff @(posedge clk) begin
      if (rd_rst) begin
        rd_dout <= '0;
      end else if (rd_en) begin
        rd_dout <= mem[rd_addr];
      end
    end
  end else begin : g_distributed
    (* ram_style = "distributed" *)
    logic [DATA_BITS-1:0] mem [Depth];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_din;
      end
    end

    always_ff @(posedge clk) begin
      if (rd_rst) begin
        rd_dout <= '0;
      end else if (rd_en) begin
        rd_dout <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/jelly3_fifo_fwft.sv
// jelly3_fifo_fwft
// Single-clock first-word-fall-through FIFO with valid/ready stream ports.
// Total capacity is exactly DEPTH = 2**PTR_BITS words, counting words held in
// the RAM read register and (DOUT_REG=1) the output register.
// Optional feature: define JELLY3_FIFO_PEAK_COUNT_EN to build the peak_count
// high-water-mark register; otherwise peak_count is tied to 0.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cke               clock enable, 0 freezes all state
//   clear             synchronous flush (reset > clear > cke)
//   s_data/valid/ready   write stream; s_ready is registered
//   m_data/valid/ready   read stream (FWFT)
//   almost_full_th    almost_full  = data_count >= th (registered)
//   almost_empty_th   almost_empty = data_count <= th (registered)
//   data_count        words held; free_count = DEPTH - data_count
//   peak_count        high-water mark of data_count

module jelly3_fifo_fwft
  import jelly3_fifo_pkg::*;
#(
  parameter int    DATA_BITS = 8,
  parameter int    PTR_BITS  = 5,
  parameter string RAM_TYPE  = "distributed",
  parameter int    DOUT_REG  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 clear,

  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,

  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,

  input  logic [PTR_BITS:0]    almost_full_th,
  input  logic [PTR_BITS:0]    almost_empty_th,
  output logic [PTR_BITS:0]    data_count,
  output logic [PTR_BITS:0]    free_count,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_BITS:0]    peak_count
);

  localparam int CountBits = count_bits(PTR_BITS);
  localparam int Depth     = 2 ** PTR_BITS;

  typedef logic [CountBits-1:0] count_t;
  typedef logic [PTR_BITS-1:0]  ptr_t;

  localparam count_t DepthC = count_t'(Depth);

  logic                 flush;
  logic                 push;
  logic                 pop;
  logic                 rd_en;
  logic                 ram_has_data;
  logic [DATA_BITS-1:0] ram_rdata;

  ptr_t   wr_ptr_q;
  ptr_t   rd_ptr_q;
  count_t count_q;
  count_t count_d;
  count_t staged;     // words already read out of the RAM but not yet popped
  logic   s_ready_q;
  logic   almost_full_q;
  logic   almost_empty_q;

  assign flush = reset | clear;
  assign push  = s_valid & s_ready_q & cke;
  assign pop   = m_valid & m_ready & cke;

  // Words still sitting in the RAM; pointer compare alone cannot tell full from
  // empty, the counter can.
  assign ram_has_data = (count_q != staged);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + count_t'(1);
      2'b01:   count_d = count_q - count_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      s_ready_q      <= 1'b1;
      almost_full_q  <= (almost_full_th == '0);
      almost_empty_q <= 1'b1;
    end else if (cke) begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      count_q        <= count_d;
      s_ready_q      <= (count_d != DepthC);
      almost_full_q  <= (count_d >= almost_full_th);
      almost_empty_q <= (count_d <= almost_empty_th);
    end
  end

  jelly3_ram_simple_dualport #(
    .ADDR_BITS (PTR_BITS),
    .DATA_BITS (DATA_BITS),
    .RAM_TYPE  (RAM_TYPE)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_din  (s_data),
    .rd_rst  (flush),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_dout (ram_rdata)
  );

  if (DOUT_REG != 0) begin : g_dout_reg
    // Stage 0 is the RAM read register, stage 1 the output register. Stage 0
    // acts as the skid slot: it only refills when it is empty or moving on.
    logic                 v0_q;
    logic                 v1_q;
    logic [DATA_BITS-1:0] d1_q;
    logic                 move01;

    assign move01 = cke & v0_q & (~v1_q | m_ready);
    assign rd_en  = cke & ram_has_data & (~v0_q | move01);
    assign staged = count_t'(v0_q) + count_t'(v1_q);

    always_ff @(posedge clk) begin
      if (flush) begin
        v0_q <= 1'b0;
        v1_q <= 1'b0;
        d1_q <= '0;
      end else if (cke) begin
        if (rd_en) begin
          v0_q <= 1'b1;
        end else if (move01) begin
          v0_q <= 1'b0;
        end
        if (move01) begin
          v1_q <= 1'b1;
          d1_q <= ram_rdata;
        end else if (pop) begin
          v1_q <= 1'b0;
        end
      end
    end

    assign m_valid = v1_q;
    assign m_data  = d1_q;
  end else begin : g_dout_ram
    // The RAM read register is the output stage.
    logic v0_q;

    assign rd_en  = cke & ram_has_data & (~v0_q | m_ready);
    assign staged = count_t'(v0_q);

    always_ff @(posedge clk) begin
      if (flush) begin
        v0_q <= 1'b0;
      end else if (cke) begin
        if (rd_en) begin
          v0_q <= 1'b1;
        end else if (pop) begin
          v0_q <= 1'b0;
        end
      end
    end

    assign m_valid = v0_q;
    assign m_data  = ram_rdata;
  end

`ifdef JELLY3_FIFO_PEAK_COUNT_EN
  count_t peak_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      peak_q <= '0;
    end else if (cke && (count_d > peak_q)) begin
      peak_q <= count_d;
    end
  end

  assign peak_count = peak_q;
`else
  assign peak_count = '0;
`endif

  assign s_ready      = s_ready_q;
  assign data_count   = count_q;
  assign free_count   = DepthC - count_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

endmodule

// File: tb/tb_jelly3_fifo_fwft.sv
// Bench for jelly3_fifo_fwft: two instances (DOUT_REG=0 and DOUT_REG=1, PTR_BITS=4)
// share one stimulus stream. A queue model predicts every output each cycle:
// a word is visible at m_valid once it has aged 1+DOUT_REG enabled edges.

module tb_jelly3_fifo_fwft;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       reset, cke, clear, s_valid, m_ready;
  logic [7:0] s_data;
  logic [4:0] af_th, ae_th;

  logic       s_ready_w [2];
  logic       m_valid_w [2];
  logic       af_w      [2];
  logic       ae_w      [2];
  logic [7:0] m_data_w  [2];
  logic [4:0] dc_w      [2];
  logic [4:0] fc_w      [2];
  logic [4:0] pk_w      [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    jelly3_fifo_fwft #(
      .DATA_BITS (8),
      .PTR_BITS  (4),
      .RAM_TYPE  (g == 0 ? "distributed" : "block"),
      .DOUT_REG  (g)
    ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .cke             (cke),
      .clear           (clear),
      .s_data          (s_data),
      .s_valid         (s_valid),
      .s_ready         (s_ready_w[g]),
      .m_data          (m_data_w[g]),
      .m_valid         (m_valid_w[g]),
      .m_ready         (m_ready),
      .almost_full_th  (af_th),
      .almost_empty_th (ae_th),
      .data_count      (dc_w[g]),
      .free_count      (fc_w[g]),
      .almost_full     (af_w[g]),
      .almost_empty    (ae_w[g]),
      .peak_count      (pk_w[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: circular queue per instance plus push timestamps.
  logic [7:0] md [2][32];
  int         mt [2][32];
  int         mh [2];
  int         mn [2];
  int         en_no = 0;
  logic       e_sready [2];
  logic       e_af     [2];
  logic       e_ae     [2];
  logic       e_zero   [2];
  int         e_peak   [2];

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp);
    end
  endtask

  function automatic logic exp_mvalid(input int i);
    return (mn[i] > 0) && ((en_no - mt[i][mh[i]]) >= (1 + i));
  endfunction

  task automatic tick();
    logic push [2];
    logic pop  [2];
    logic mv;
    for (int i = 0; i < 2; i++) begin
      push[i] = s_valid && e_sready[i] && cke;
      pop[i]  = exp_mvalid(i) && m_ready && cke;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset || clear) begin
        mh[i] = 0;
        mn[i] = 0;
        e_sready[i] = 1'b1;
        e_af[i] = (af_th == 0);
        e_ae[i] = 1'b1;
        e_zero[i] = 1'b1;
        e_peak[i] = 0;
      end else if (cke) begin
        if (pop[i]) begin
          mh[i] = (mh[i] + 1) % 32;
          mn[i]--;
        end
        if (push[i]) begin
          md[i][(mh[i] + mn[i]) % 32] = s_data;
          mt[i][(mh[i] + mn[i]) % 32] = en_no + 1;
          mn[i]++;
        end
        e_sready[i] = (mn[i] != Depth);
        e_af[i] = (mn[i] >= int'(af_th));
        e_ae[i] = (mn[i] <= int'(ae_th));
        if (mn[i] > e_peak[i]) e_peak[i] = mn[i];
      end
    end
    if (!(reset || clear) && cke) en_no++;
    #1;
    for (int i = 0; i < 2; i++) begin
      mv = exp_mvalid(i);
      chk("s_ready", i, s_ready_w[i], e_sready[i]);
      chk("m_valid", i, m_valid_w[i], mv);
      if (mv) begin
        chk("m_data", i, m_data_w[i], md[i][mh[i]]);
        e_zero[i] = 1'b0;
      end else if (e_zero[i]) begin
        chk("m_data_rst", i, m_data_w[i], 0);
      end
      chk("data_count", i, dc_w[i], mn[i]);
      chk("free_count", i, fc_w[i], Depth - mn[i]);
      chk("almost_full", i, af_w[i], e_af[i]);
      chk("almost_empty", i, ae_w[i], e_ae[i]);
`ifdef JELLY3_FIFO_PEAK_COUNT_EN
      chk("peak_count", i, pk_w[i], e_peak[i]);
`else
      chk("peak_count", i, pk_w[i], 0);
`endif
    end
  endtask

  initial begin
    int lat [2];
    int bub [2];

    reset = 1'b1; cke = 1'b1; clear = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    s_data = 8'd0; af_th = 5'd12; ae_th = 5'd2;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Fill with 1..16, no reads.
    s_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      s_data = 8'(k);
      tick();
    end
    s_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("full_count", i, dc_w[i], 16);
      chk("full_sready", i, s_ready_w[i], 0);
      chk("full_free", i, fc_w[i], 0);
      chk("full_af", i, af_w[i], 1);
    end

    // Drain: 1..16 on consecutive cycles.
    m_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      for (int i = 0; i < 2; i++) begin
        chk("drain_valid", i, m_valid_w[i], (k < 16) ? 1 : 0);
        if (k < 16) chk("drain_data", i, m_data_w[i], k + 1);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      chk("empty_count", i, dc_w[i], 0);
      chk("empty_ae", i, ae_w[i], 1);
    end

    // First-word latency into an empty FIFO.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hA5;
    tick();
    s_valid = 1'b0;
    lat[0] = -1;
    lat[1] = -1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      for (int i = 0; i < 2; i++) if (lat[i] < 0 && m_valid_w[i]) lat[i] = e;
    end
    for (int i = 0; i < 2; i++) begin
      chk("latency", i, lat[i], 1 + i);
      chk("latency_data", i, m_data_w[i], 8'hA5);
    end
    m_ready = 1'b1;
    repeat (3) tick();

    // Sustained streaming across pointer wrap.
    s_valid = 1'b1;
    bub[0] = 0;
    bub[1] = 0;
    for (int k = 0; k < 100; k++) begin
      s_data = 8'($urandom);
      tick();
      if (k >= 3) for (int i = 0; i < 2; i++) if (!m_valid_w[i]) bub[i]++;
    end
    for (int i = 0; i < 2; i++) chk("bubbles", i, bub[i], 0);
    s_valid = 1'b0;
    repeat (4) tick();

    // Threshold boundaries with 3 words held.
    m_ready = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin
      s_data = 8'($urandom);
      tick();
    end
    s_valid = 1'b0;
    af_th = 5'd0; ae_th = 5'd16;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("af_th0", i, af_w[i], 1);
      chk("ae_th16", i, ae_w[i], 1);
    end
    ae_th = 5'd31; af_th = 5'd4;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("ae_th31", i, ae_w[i], 1);
      chk("af_th4", i, af_w[i], 0);
    end
    af_th = 5'd3; ae_th = 5'd2;
    tick();
    for (int i = 0; i < 2; i++) chk("af_th3", i, af_w[i], 1);

    // cke=0 freezes everything.
    cke = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) chk("cke_hold", i, dc_w[i], 3);
    cke = 1'b1; s_valid = 1'b0;
    repeat (5) tick();

    // Clear after filling to 10, then refill to 5.
    m_ready = 1'b0; s_valid = 1'b1; af_th = 5'd12;
    for (int k = 0; k < 10; k++) begin
      s_data = 8'(k + 40);
      tick();
    end
    s_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("clr_count", i, dc_w[i], 0);
      chk("clr_valid", i, m_valid_w[i], 0);
      chk("clr_peak", i, pk_w[i], 0);
    end
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = 8'(k + 80);
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 2; i++) begin
`ifdef JELLY3_FIFO_PEAK_COUNT_EN
      chk("peak_after", i, pk_w[i], 5);
`else
      chk("peak_after", i, pk_w[i], 0);
`endif
    end

    // Random traffic with alternating fill/drain bias.
    for (int c = 0; c < 10000; c++) begin
      if (((c / 500) % 2) == 0) begin
        s_valid = ($urandom_range(0, 3) != 0);
        m_ready = ($urandom_range(0, 3) == 0);
      end else begin
        s_valid = ($urandom_range(0, 3) == 0);
        m_ready = ($urandom_range(0, 3) != 0);
      end
      s_data = 8'($urandom);
      cke = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) af_th = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) ae_th = 5'($urandom_range(0, 31));
      tick();
    end
    clear = 1'b0; cke = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
